// File: rtl/video_pkg.sv
// Shared video definitions: pattern mode encodings, colour-bar palette and
// default 800x600 raster timing (also used by the transceiver instantiation).
package video_pkg;

  localparam int unsigned CNT_W  = 26;  // raster counter width from transceiver
  localparam int unsigned MODE_W = 3;
  localparam int unsigned CH_W   = 8;

  localparam int unsigned H_PIXEL_DEF     = 800;
  localparam int unsigned H_TOT_PIXEL_DEF = 1056;
  localparam int unsigned V_PIXEL_DEF     = 600;
  localparam int unsigned V_TOT_PIXEL_DEF = 628;

  typedef enum logic [MODE_W-1:0] {
    MODE_BLACK = 3'd0,
    MODE_BARS  = 3'd1,
    MODE_GRAD  = 3'd2,
    MODE_CHECK = 3'd3,
    MODE_BOX   = 3'd4
  } mode_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  localparam rgb_t COL_WHITE   = 24'hFF_FF_FF;
  localparam rgb_t COL_YELLOW  = 24'hFF_FF_00;
  localparam rgb_t COL_CYAN    = 24'h00_FF_FF;
  localparam rgb_t COL_GREEN   = 24'h00_FF_00;
  localparam rgb_t COL_MAGENTA = 24'hFF_00_FF;
  localparam rgb_t COL_RED     = 24'hFF_00_00;
  localparam rgb_t COL_BLUE    = 24'h00_00_FF;
  localparam rgb_t COL_BLACK   = 24'h00_00_00;

  // Colour-bar palette lookup, index 0 = leftmost bar of the top half.
  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/box_animator.sv
// One axis of the bouncing box: position register plus INC/DEC direction.
// Ports: pixclk, rst (async high), step_en (frame boundary), pos (box origin).
module box_animator
  import video_pkg::*;
#(
  parameter int unsigned LIMIT = 736,
  parameter int unsigned STEP  = 4
) (
  input  logic             pixclk,
  input  logic             rst,
  input  logic             step_en,
  output logic [CNT_W-1:0] pos
);

  dir_e dir;

  // Move one step per frame, clamping to the edge and reversing there.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      pos <= '0;
      dir <= DIR_INC;
    end else if (step_en) begin
      case (dir)
        DIR_INC: begin
          if (pos + CNT_W'(STEP) > CNT_W'(LIMIT)) begin
            pos <= CNT_W'(LIMIT);
            dir <= DIR_DEC;
          end else begin
            pos <= pos + CNT_W'(STEP);
          end
        end
        default: begin
          if (pos < CNT_W'(STEP)) begin
            pos <= '0;
            dir <= DIR_INC;
          end else begin
            pos <= pos - CNT_W'(STEP);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Video test-pattern source for the HDMI transceiver RGB inputs.
// Ports: pixclk, rst (async high); cntX/cntY raster position; mode_sel +
// mode_load strobe; red/green/blue/de pixel outputs (1-cycle latency);
// frame_tick, frame_cnt, mode_active status.
module test_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned H_PIXEL     = H_PIXEL_DEF,
  parameter int unsigned H_TOT_PIXEL = H_TOT_PIXEL_DEF,
  parameter int unsigned V_PIXEL     = V_PIXEL_DEF,
  parameter int unsigned V_TOT_PIXEL = V_TOT_PIXEL_DEF,
  parameter int unsigned NUM_BARS    = 8,
  parameter int unsigned GRAD_SHIFT  = 2,
  parameter int unsigned CHK_LOG2    = 5,
  parameter int unsigned BOX_SIZE    = 64,
  parameter int unsigned BOX_STEP    = 4,
  parameter int unsigned RESET_MODE  = 1
) (
  input  logic              pixclk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cntX,
  input  logic [CNT_W-1:0]  cntY,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              mode_load,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              de,
  output logic              frame_tick,
  output logic [15:0]       frame_cnt,
  output logic [MODE_W-1:0] mode_active
);

  localparam int unsigned BAR_W = H_PIXEL / NUM_BARS;

  logic [CNT_W-1:0]  pos_cnt;
  logic [2:0]        bar_cnt;
  logic [MODE_W-1:0] pend_mode;
  logic [CNT_W-1:0]  bx, by;
  logic              h_act_c, active_c, line_end_c, fb_c, in_box_c;
  logic [CNT_W-1:0]  grad_c;
  logic [2:0]        bar_idx_c;
  rgb_t              pix_c;

  assign h_act_c    = cntX < CNT_W'(H_PIXEL);
  assign active_c   = h_act_c && (cntY < CNT_W'(V_PIXEL));
  assign line_end_c = cntX == CNT_W'(H_TOT_PIXEL - 1);
  assign fb_c       = line_end_c && (cntY == CNT_W'(V_TOT_PIXEL - 1));
  assign grad_c     = cntX >> GRAD_SHIFT;
  assign in_box_c   = (cntX >= bx) && (cntX < bx + CNT_W'(BOX_SIZE)) &&
                      (cntY >= by) && (cntY < by + CNT_W'(BOX_SIZE));
  // Bottom half mirrors the bar order.
  assign bar_idx_c  = (cntY < CNT_W'(V_PIXEL / 2)) ? bar_cnt
                                                   : 3'(NUM_BARS - 1) - bar_cnt;

  // Divider-free bar index: count active pixels, advance every BAR_W, and
  // saturate so remainder pixels keep the last bar colour.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      pos_cnt <= '0;
      bar_cnt <= '0;
    end else if (line_end_c) begin
      pos_cnt <= '0;
      bar_cnt <= '0;
    end else if (h_act_c) begin
      if (pos_cnt == CNT_W'(BAR_W - 1)) begin
        pos_cnt <= '0;
        if (bar_cnt != 3'(NUM_BARS - 1)) bar_cnt <= bar_cnt + 3'd1;
      end else begin
        pos_cnt <= pos_cnt + CNT_W'(1);
      end
    end
  end

  // Pattern colour for the current raster position.
  always_comb begin
    pix_c = COL_BLACK;
    case (mode_active)
      MODE_BARS:  pix_c = bar_color(bar_idx_c);
      MODE_GRAD:  pix_c = {grad_c[7:0], grad_c[7:0], grad_c[7:0]};
      MODE_CHECK: if (cntX[CHK_LOG2] ^ cntY[CHK_LOG2]) pix_c = COL_WHITE;
      MODE_BOX:   pix_c = in_box_c ? COL_WHITE : COL_BLUE;
      default:    pix_c = COL_BLACK;
    endcase
  end

  // Registered pixel outputs and frame-synchronous mode/counter updates.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      de          <= 1'b0;
      frame_tick  <= 1'b0;
      frame_cnt   <= '0;
      mode_active <= MODE_W'(RESET_MODE);
      pend_mode   <= MODE_W'(RESET_MODE);
    end else begin
      de         <= active_c;
      red        <= active_c ? pix_c.r : '0;
      green      <= active_c ? pix_c.g : '0;
      blue       <= active_c ? pix_c.b : '0;
      frame_tick <= fb_c;
      if (mode_load) pend_mode <= mode_sel;
      if (fb_c) begin
        frame_cnt   <= frame_cnt + 16'd1;
        mode_active <= mode_load ? mode_sel : pend_mode;
      end
    end
  end

  box_animator #(.LIMIT(H_PIXEL - BOX_SIZE), .STEP(BOX_STEP)) u_box_x (
    .pixclk  (pixclk),
    .rst     (rst),
    .step_en (fb_c),
    .pos     (bx)
  );

  box_animator #(.LIMIT(V_PIXEL - BOX_SIZE), .STEP(BOX_STEP)) u_box_y (
    .pixclk  (pixclk),
    .rst     (rst),
    .step_en (fb_c),
    .pos     (by)
  );

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen with default 800x600 timing.
module tb_test_pattern_gen;

  localparam int H = 800, HT = 1056, V = 600, VT = 628;
  localparam int NB = 8, BW = 100, BOX = 64, STEP = 4;

  logic        pixclk = 1'b0;
  logic        rst = 1'b1;
  logic [25:0] cntX = '0, cntY = '0;
  logic [2:0]  mode_sel = '0;
  logic        mode_load = 1'b0;
  logic [7:0]  red, green, blue;
  logic        de, frame_tick;
  logic [15:0] frame_cnt;
  logic [2:0]  mode_active;

  test_pattern_gen dut (
    .pixclk(pixclk), .rst(rst), .cntX(cntX), .cntY(cntY),
    .mode_sel(mode_sel), .mode_load(mode_load),
    .red(red), .green(green), .blue(blue), .de(de),
    .frame_tick(frame_tick), .frame_cnt(frame_cnt), .mode_active(mode_active)
  );

  always #5 pixclk = ~pixclk;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        tick;
    logic [15:0] cnt;
    logic [2:0]  mode;
  } exp_t;

  typedef struct {
    exp_t v;
    int   x;
    int   y;
  } obs_t;

  exp_t sb[$];
  obs_t obs_q[$];
  int   n_cmp = 0, n_err = 0;

  // Reference model state
  int m_mode, m_pend, m_cnt, bx, by;
  bit dx, dy;

  function automatic logic [23:0] pal(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset;
    m_mode = 1; m_pend = 1; m_cnt = 0;
    bx = 0; by = 0; dx = 1'b0; dy = 1'b0;
  endtask

  task automatic bounce(inout int p, inout bit d, input int lim);
    if (!d) begin
      if (p + STEP > lim) begin p = lim; d = 1'b1; end
      else p = p + STEP;
    end else begin
      if (p < STEP) begin p = 0; d = 1'b0; end
      else p = p - STEP;
    end
  endtask

  // Drive one raster position, push the model's expectation, capture output.
  task automatic step(input int x, input int y, input int ms = 0, input bit ml = 1'b0);
    exp_t e;
    obs_t o;
    logic [23:0] c;
    logic [7:0] g;
    bit act, fb;
    int b;
    cntX = 26'(x); cntY = 26'(y); mode_sel = 3'(ms); mode_load = ml;
    act = (x < H) && (y < V);
    fb  = (x == HT - 1) && (y == VT - 1);
    c = 24'h0;
    case (m_mode)
      1: begin
        b = x / BW;
        if (b > NB - 1) b = NB - 1;
        c = pal((y < V / 2) ? b : NB - 1 - b);
      end
      2: begin g = 8'((x >> 2) & 255); c = {g, g, g}; end
      3: c = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      4: c = (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 24'hFFFFFF : 24'h0000FF;
      default: c = 24'h0;
    endcase
    if (ml) m_pend = ms;
    if (fb) begin
      m_cnt  = (m_cnt + 1) & 16'hFFFF;
      m_mode = m_pend;
      bounce(bx, dx, H - BOX);
      bounce(by, dy, V - BOX);
    end
    e.rgb = act ? c : 24'h0; e.de = act; e.tick = fb;
    e.cnt = 16'(m_cnt); e.mode = 3'(m_mode);
    sb.push_back(e);
    @(posedge pixclk); #1;
    mode_load = 1'b0;
    o.v = {red, green, blue, de, frame_tick, frame_cnt, mode_active};
    o.x = x; o.y = y;
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    exp_t got;
    rst = 1'b1;
    repeat (3) @(posedge pixclk);
    #1;
    got = {red, green, blue, de, frame_tick, frame_cnt, mode_active};
    n_cmp++;
    if (got !== {24'h0, 1'b0, 1'b0, 16'h0, 3'd1}) begin
      n_err++;
      $display("FAIL reset: got %h required rgb/de/tick/cnt=0 mode=1", got);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_bars;
    obs_t o; exp_t ex;
    for (int x = 0; x < HT; x++) step(x, 0);
    for (int x = 0; x < HT; x++) step(x, 300);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); ex = sb.pop_front(); n_cmp++;
      if (o.v !== ex) begin
        n_err++;
        $display("FAIL bars (%0d,%0d): got %h expected %h", o.x, o.y, o.v, ex);
      end
    end
  endtask

  task automatic test_mode_switch;
    obs_t o; exp_t ex;
    step(0, 100, 3, 1'b1);
    step(HT - 1, 100);
    for (int x = 0; x < HT; x++) step(x, 200);
    step(HT - 1, VT - 1);
    step(0, 0);
    step(32, 0);
    step(32, 32);
    step(HT - 1, 0);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); ex = sb.pop_front(); n_cmp++;
      if (o.v !== ex) begin
        n_err++;
        $display("FAIL mode_switch (%0d,%0d): got %h expected %h", o.x, o.y, o.v, ex);
      end
    end
  endtask

  task automatic test_grey;
    obs_t o; exp_t ex;
    step(0, 5, 2, 1'b1);
    step(HT - 1, VT - 1);
    step(799, 0);
    step(1023, 0);
    step(400, 10);
    step(3, 599);
    step(3, 600);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); ex = sb.pop_front(); n_cmp++;
      if (o.v !== ex) begin
        n_err++;
        $display("FAIL grey (%0d,%0d): got %h expected %h", o.x, o.y, o.v, ex);
      end
    end
  endtask

  task automatic test_box;
    obs_t o; exp_t ex;
    step(0, 0, 4, 1'b1);
    step(HT - 1, VT - 1);
    for (int f = 0; f < 200; f++) begin
      step(bx, by);
      step(bx + BOX, by);
      step(bx + BOX - 1, by + BOX - 1);
      if (bx > 0) step(bx - 1, by);
      if (by > 0) step(bx, by - 1);
      step(HT - 1, VT - 1);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); ex = sb.pop_front(); n_cmp++;
      if (o.v !== ex) begin
        n_err++;
        $display("FAIL box (%0d,%0d): got %h expected %h", o.x, o.y, o.v, ex);
      end
    end
  endtask

  task automatic test_fb_load;
    obs_t o; exp_t ex;
    step(10, 10);
    step(HT - 1, VT - 1, 6, 1'b1);
    step(10, 10);
    step(500, 300);
    step(HT - 1, VT - 2);
    step(0, 0);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); ex = sb.pop_front(); n_cmp++;
      if (o.v !== ex) begin
        n_err++;
        $display("FAIL fb_load (%0d,%0d): got %h expected %h", o.x, o.y, o.v, ex);
      end
    end
  endtask

  task automatic test_reset_mid;
    obs_t o; exp_t ex, got;
    rst = 1'b1;
    @(posedge pixclk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) step(HT - 1, VT - 1);
    for (int x = 0; x < 400; x++) step(x, 10);
    // Asynchronous assertion between clock edges
    rst = 1'b1;
    #1;
    got = {red, green, blue, de, frame_tick, frame_cnt, mode_active};
    n_cmp++;
    if (got !== {24'h0, 1'b0, 1'b0, 16'h0, 3'd1}) begin
      n_err++;
      $display("FAIL reset_async: got %h required rgb/de/tick/cnt=0 mode=1", got);
    end
    @(posedge pixclk); #1;
    rst = 1'b0;
    model_reset();
    step(HT - 1, 10);
    for (int x = 0; x < HT; x++) step(x, 11);
    step(0, 0, 4, 1'b1);
    step(HT - 1, VT - 1);
    step(4, 4);
    step(3, 4);
    step(67, 67);
    step(68, 4);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); ex = sb.pop_front(); n_cmp++;
      if (o.v !== ex) begin
        n_err++;
        $display("FAIL reset_mid (%0d,%0d): got %h expected %h", o.x, o.y, o.v, ex);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bars();
    test_mode_switch();
    test_grey();
    test_box();
    test_fb_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
